// File: rtl/psdsqrt_gen.sv
// Multi-cycle rounded square root: digit-by-digit restoring method, BPC root bits per clock.
// Optional macro PSDSQRT_REM_EN exposes the final remainder X - T^2 on port rem.
module psdsqrt_gen #(
  parameter int NBITS   = 32,
  parameter int DECIMAL = 4,
  parameter int BPC     = 1
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      start,
  input  logic [1:0]                rmode,
  input  logic [NBITS-1:0]          xin,
  output logic                      busy,
  output logic                      done,
  output logic [NBITS/2-1:0]        sqrt,
  output logic                      ovf
`ifdef PSDSQRT_REM_EN
  ,
  output logic [NBITS/2+DECIMAL:0]  rem
`endif
);

  localparam int H2    = NBITS / 2;
  localparam int W     = NBITS + 2 * DECIMAL;
  localparam int R     = H2 + DECIMAL;
  localparam int NITER = R / BPC;
  localparam int CW    = $clog2(NITER + 1);
  localparam logic [DECIMAL-1:0] HALF = DECIMAL'(1) << (DECIMAL - 1);

  typedef enum logic [1:0] {IDLE, RUN, ROUND} state_t;

  state_t         state_q;
  logic [W-1:0]   x_q;
  logic [R-1:0]   root_q;
  logic [R:0]     rem_q;
  logic [1:0]     mode_q;
  logic [CW-1:0]  cnt_q;
  logic           busy_q;
  logic           done_q;
  logic [H2-1:0]  sqrt_q;
  logic           ovf_q;
`ifdef PSDSQRT_REM_EN
  logic [R:0]     rem_out_q;
`endif

  // Combinational chain of BPC restoring stages; stage gi consumes the gi-th radicand pair.
  logic [R:0]   rem_c  [BPC+1];
  logic [R-1:0] root_c [BPC+1];

  assign rem_c[0]  = rem_q;
  assign root_c[0] = root_q;

  generate
    for (genvar gi = 0; gi < BPC; gi++) begin : g_stage
      logic [R+2:0] rem_sh;
      logic [R+2:0] trial;
      logic         ge;
      assign rem_sh = {rem_c[gi], x_q[W-1-2*gi -: 2]};
      assign trial  = {1'b0, root_c[gi], 2'b01};
      assign ge     = (rem_sh >= trial);
      assign rem_c[gi+1]  = ge ? (R+1)'(rem_sh - trial) : (R+1)'(rem_sh);
      assign root_c[gi+1] = R'({root_c[gi], ge});
    end
  endgenerate

  logic [H2-1:0]      int_part;
  logic [DECIMAL-1:0] frac;
  logic               sticky;
  logic               inc;
  logic [H2:0]        sum;
  logic [H2-1:0]      sqrt_d;
  logic               ovf_d;

  always_comb begin
    int_part = root_q[R-1:DECIMAL];
    frac     = root_q[DECIMAL-1:0];
    sticky   = |rem_q;
    inc      = 1'b0;
    case (mode_q)
      2'd1:    inc = (frac > HALF) || ((frac == HALF) && int_part[0]);
      2'd2:    inc = (frac > HALF) || ((frac == HALF) && (sticky || int_part[0]));
      2'd3:    inc = (|frac) || sticky;
      default: inc = 1'b0;
    endcase
    sum    = {1'b0, int_part} + (H2+1)'(inc);
    // Carry out of the increment saturates rather than wrapping to zero.
    sqrt_d = sum[H2] ? {H2{1'b1}} : sum[H2-1:0];
    ovf_d  = sum[H2];
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      x_q       <= '0;
      root_q    <= '0;
      rem_q     <= '0;
      mode_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sqrt_q    <= '0;
      ovf_q     <= 1'b0;
`ifdef PSDSQRT_REM_EN
      rem_out_q <= '0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q     <= {xin, {(2*DECIMAL){1'b0}}};
            mode_q  <= rmode;
            root_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          x_q    <= x_q << (2 * BPC);
          root_q <= root_c[BPC];
          rem_q  <= rem_c[BPC];
          cnt_q  <= cnt_q + CW'(1);
          if (cnt_q == CW'(NITER - 1)) state_q <= ROUND;
        end
        ROUND: begin
          sqrt_q    <= sqrt_d;
          ovf_q     <= ovf_d;
`ifdef PSDSQRT_REM_EN
          rem_out_q <= rem_q;
`endif
          done_q    <= 1'b1;
          busy_q    <= 1'b0;
          state_q   <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sqrt = sqrt_q;
  assign ovf  = ovf_q;
`ifdef PSDSQRT_REM_EN
  assign rem  = rem_out_q;
`endif

endmodule

// File: tb/tb_psdsqrt_gen.sv
// Bench for psdsqrt_gen: BPC=1 and BPC=2 instances share stimulus; results checked against a
// binary-search integer square-root model and a table of known vectors.
module tb_psdsqrt_gen;

  localparam int NB  = 32;
  localparam int DEC = 4;
  localparam int R   = NB/2 + DEC;
  localparam int LAT1 = R + 1;
  localparam int LAT2 = R/2 + 1;
  localparam longint HALF = 64'd1 << (DEC-1);

  logic          clock = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    rmode;
  logic [NB-1:0] xin;
  logic          busy1, done1, ovf1, busy2, done2, ovf2;
  logic [15:0]   sqrt1, sqrt2;
`ifdef PSDSQRT_REM_EN
  logic [R:0]    rem1, rem2;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  psdsqrt_gen #(.NBITS(NB), .DECIMAL(DEC), .BPC(1)) dut1 (
    .clock(clock), .reset(reset), .start(start), .rmode(rmode), .xin(xin),
    .busy(busy1), .done(done1), .sqrt(sqrt1), .ovf(ovf1)
`ifdef PSDSQRT_REM_EN
    , .rem(rem1)
`endif
  );

  psdsqrt_gen #(.NBITS(NB), .DECIMAL(DEC), .BPC(2)) dut2 (
    .clock(clock), .reset(reset), .start(start), .rmode(rmode), .xin(xin),
    .busy(busy2), .done(done2), .sqrt(sqrt2), .ovf(ovf2)
`ifdef PSDSQRT_REM_EN
    , .rem(rem2)
`endif
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: largest t with t*t <= X by binary search, then the rounding rules on plain integers.
  function automatic void model(input logic [31:0] x, input logic [1:0] m,
                                output logic [15:0] s, output logic o, output longint r);
    longint big_x, lo, hi, mid, ip, fr, val;
    bit up, st;
    big_x = longint'({32'd0, x}) << (2*DEC);
    lo = 0;
    hi = (longint'(1) << R) - 1;
    while (lo < hi) begin
      mid = (lo + hi + 1) / 2;
      if (mid * mid <= big_x) lo = mid;
      else hi = mid - 1;
    end
    r  = big_x - lo * lo;
    ip = lo >> DEC;
    fr = lo % (longint'(1) << DEC);
    st = (r != 0);
    case (m)
      2'd0: up = 1'b0;
      2'd1: up = (fr > HALF) || (fr == HALF && (ip % 2 == 1));
      2'd2: up = (fr > HALF) || (fr == HALF && (st || (ip % 2 == 1)));
      default: up = (fr != 0) || st;
    endcase
    val = ip + (up ? 1 : 0);
    if (val > 65535) begin s = 16'hFFFF; o = 1'b1; end
    else begin s = val[15:0]; o = 1'b0; end
  endfunction

  logic [15:0] res_s1, res_s2;
  logic        res_o1, res_o2;
  longint      res_r1, res_r2;
  int          lat1, lat2;

  task automatic do_op(input string tag, input logic [31:0] x, input logic [1:0] m, input int repulse);
    logic [15:0] es;
    logic        eo;
    longint      er;
    bit          busy_ok;
    busy_ok = 1'b1;
    lat1 = -1; lat2 = -1;
    res_s1 = 'x; res_s2 = 'x; res_o1 = 'x; res_o2 = 'x; res_r1 = -1; res_r2 = -1;
    @(negedge clock);
    xin = x; rmode = m; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clock); #1;
      if (repulse != 0 && k == repulse) begin
        start = 1'b1; xin = 32'd4; rmode = 2'd0;
      end
      if (repulse != 0 && k == repulse + 1) start = 1'b0;
      if (busy1 !== (k < LAT1)) busy_ok = 1'b0;
      if (lat2 < 0 && busy2 !== (k < LAT2)) busy_ok = 1'b0;
      if (done2 === 1'b1 && lat2 < 0) begin
        lat2 = k; res_s2 = sqrt2; res_o2 = ovf2;
`ifdef PSDSQRT_REM_EN
        res_r2 = longint'(rem2);
`endif
      end
      if (done1 === 1'b1) begin
        lat1 = k; res_s1 = sqrt1; res_o1 = ovf1;
`ifdef PSDSQRT_REM_EN
        res_r1 = longint'(rem1);
`endif
        break;
      end
    end
    start = 1'b0;
    model(x, m, es, eo, er);
    $display("op %s x=%0h mode=%0d sqrt=%0d/%0d ovf=%0d/%0d lat=%0d/%0d model=%0d,%0d rem=%0d",
             tag, x, m, res_s1, res_s2, res_o1, res_o2, lat1, lat2, es, eo, er);
    chk({tag, " lat1"}, 64'(lat1), 64'(LAT1));
    chk({tag, " lat2"}, 64'(lat2), 64'(LAT2));
    chk({tag, " busy"}, 64'(busy_ok), 64'd1);
    chk({tag, " sqrt1"}, 64'(res_s1), 64'(es));
    chk({tag, " ovf1"}, 64'(res_o1), 64'(eo));
    chk({tag, " sqrt2"}, 64'(res_s2), 64'(es));
    chk({tag, " ovf2"}, 64'(res_o2), 64'(eo));
`ifdef PSDSQRT_REM_EN
    chk({tag, " rem1"}, 64'(res_r1), 64'(er));
    chk({tag, " rem2"}, 64'(res_r2), 64'(er));
`endif
  endtask

  typedef struct {
    logic [31:0] x;
    logic [1:0]  m;
    logic [15:0] s;
    logic        o;
    longint      r;
  } vec_t;

  vec_t tv[13];

  initial begin
    bit saw;
    tv[0]  = '{32'd0,         2'd1, 16'd0,      1'b0, 0};
    tv[1]  = '{32'd12,        2'd0, 16'd3,      1'b0, 47};
    tv[2]  = '{32'd12,        2'd1, 16'd3,      1'b0, 47};
    tv[3]  = '{32'd12,        2'd2, 16'd3,      1'b0, 47};
    tv[4]  = '{32'd12,        2'd3, 16'd4,      1'b0, 47};
    tv[5]  = '{32'd13,        2'd0, 16'd3,      1'b0, 79};
    tv[6]  = '{32'd13,        2'd1, 16'd4,      1'b0, 79};
    tv[7]  = '{32'd13,        2'd2, 16'd4,      1'b0, 79};
    tv[8]  = '{32'd13,        2'd3, 16'd4,      1'b0, 79};
    tv[9]  = '{32'd43,        2'd1, 16'd6,      1'b0, 192};
    tv[10] = '{32'd43,        2'd2, 16'd7,      1'b0, 192};
    tv[11] = '{32'hFFFF_FFFF, 2'd1, 16'hFFFF,   1'b1, 2096895};
    tv[12] = '{32'hFFFF_FFFF, 2'd0, 16'hFFFF,   1'b0, 2096895};

    reset = 1'b0; start = 1'b0; xin = '0; rmode = '0;
    repeat (3) @(posedge clock);
    #1;
    chk("reset busy1", 64'(busy1), 64'd0);
    chk("reset done1", 64'(done1), 64'd0);
    chk("reset sqrt1", 64'(sqrt1), 64'd0);
    chk("reset ovf1",  64'(ovf1),  64'd0);
    chk("reset busy2", 64'(busy2), 64'd0);
    chk("reset sqrt2", 64'(sqrt2), 64'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 13; i++) begin
      do_op($sformatf("tbl%0d", i), tv[i].x, tv[i].m, 0);
      chk($sformatf("tbl%0d sqrt", i), 64'(res_s1), 64'(tv[i].s));
      chk($sformatf("tbl%0d ovf", i),  64'(res_o1), 64'(tv[i].o));
`ifdef PSDSQRT_REM_EN
      chk($sformatf("tbl%0d rem", i),  64'(res_r1), 64'(tv[i].r));
`endif
    end

    // A second start while busy must not disturb the running operation.
    do_op("repulse", 32'd1057, 2'd2, 5);
    chk("repulse sqrt1", 64'(res_s1), 64'd33);
    chk("repulse sqrt2", 64'(res_s2), 64'd33);
    saw = 1'b0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clock); #1;
      if (done1 === 1'b1 || done2 === 1'b1) saw = 1'b1;
    end
    chk("repulse extra done", 64'(saw), 64'd0);

    // Reset mid-operation aborts it and clears outputs.
    @(negedge clock);
    xin = 32'd4291; rmode = 2'd1; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #2 reset = 1'b0;
    #1;
    chk("abort busy1", 64'(busy1), 64'd0);
    chk("abort sqrt1", 64'(sqrt1), 64'd0);
    chk("abort busy2", 64'(busy2), 64'd0);
    chk("abort sqrt2", 64'(sqrt2), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    saw = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(posedge clock); #1;
      if (done1 === 1'b1 || done2 === 1'b1) saw = 1'b1;
    end
    chk("abort no done", 64'(saw), 64'd0);
    chk("abort sqrt1 held", 64'(sqrt1), 64'd0);

    for (int i = 0; i < 40; i++) begin
      logic [31:0] rx;
      logic [1:0]  rm;
      rx = $urandom() >> $urandom_range(0, 31);
      rm = 2'($urandom_range(0, 3));
      do_op($sformatf("rnd%0d", i), rx, rm, 0);
    end

    for (int i = 0; i < 32; i++) begin
      logic [31:0] sx;
      sx = 32'd1 << i;
      do_op($sformatf("pow%0d", i), sx, 2'($urandom_range(0, 3)), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/psdsqrt_gen.md
Name: psdsqrt_gen

Overview:
Parametrised successor of the sequential square-root unit. Computes round(sqrt(xin)) with the digit-by-digit method, retiring BPC root bits per clock. The rounding mode is selectable at run time. Overflow on round-up saturates the result. A busy/done handshake replaces the fixed-latency start/stop protocol. It sits in the datapath as a multi-cycle arithmetic slave driven by a controller.

Parameters:
- NBITS, 32, input width; even, ≥4.
- DECIMAL, 4, fractional root bits computed for rounding, ≥1.
- BPC, 1, root bits resolved per cycle (1 or 2); (NBITS/2+DECIMAL) must be divisible by BPC.

Ports:
- clock, in, 1, master clock, posedge.
- reset, in, 1, asynchronous, active-low reset.
- start, in, 1, one-cycle request; sampled only when busy=0.
- rmode, in, 2, rounding mode, latched with start: 0 truncate, 1 legacy RNE, 2 nearest with sticky, 3 ceiling.
- xin, in, NBITS, operand, latched with start.
- busy, out, 1, operation in progress.
- done, out, 1, one-cycle pulse when sqrt/ovf are updated.
- sqrt, out, NBITS/2, rounded integer root; held until the next done.
- ovf, out, 1, round-up exceeded NBITS/2 bits and the result saturated; held with sqrt.

Behaviour:
- Reset (reset=0, asynchronous): state goes to IDLE; busy=0, done=0, sqrt=0, ovf=0, rem=0; internal registers cleared. Reset mid-operation aborts the operation; no done is generated.
- Derived values: W = NBITS+2*DECIMAL, R = NBITS/2+DECIMAL, NITER = R/BPC.
- FSM:
  - IDLE: start=1 at edge E0 latches X = xin<<2*DECIMAL, latches rmode, clears the root and remainder, sets busy=1, moves to RUN.
  - RUN: each edge resolves BPC root bits, MSB first (restoring test: keep bit if partial remainder ≥ trial). After NITER edges (E1..E_NITER) moves to ROUND.
  - ROUND: edge E_NITER+1 loads sqrt/ovf, pulses done=1, clears busy, returns to IDLE.
- Latency: done is high in the cycle after edge NITER+1 from start. NBITS=32, DECIMAL=4 gives 21 cycles with BPC=1 and 11 with BPC=2.
- start while busy=1 is ignored; the in-flight operation is unaffected. start in the same cycle done is high is accepted: IDLE was re-entered at that edge.
- Rounding uses T = truncated R-bit root, I = T>>DECIMAL, F = T[DECIMAL-1:0], H = 1<<(DECIMAL-1), S = (final remainder ≠ 0):
  - mode 0: I.
  - mode 1: I+1 if F>H, or if F==H and I odd; else I. This is bit-exact with the existing psdsqrt and its model.
  - mode 2: I+1 if F>H, or if F==H and (S or I odd); else I.
  - mode 3: I+1 if F≠0 or S; else I.
- Width: the increment is done in NBITS/2+1 bits. If the carry out is set, sqrt=all-ones and ovf=1; otherwise ovf=0.
- xin=0 gives sqrt=0, ovf=0 in all modes.
- Outputs change only at the ROUND edge or on reset.

Optional Feature:
PSDSQRT_REM_EN:
- Defined: adds output port rem [R:0], the final remainder X − T², loaded at the ROUND edge alongside sqrt and reset to 0.
- Undefined: the port and its register are absent. The internal remainder is still used for the sticky bit S.

Test Plan:
- Reset, then xin=0, rmode=1, BPC=1 -> done exactly 21 cycles after the start edge; sqrt=0, ovf=0; busy high for those 21 cycles.
- xin=12, modes 0/1/2/3 -> T=55 (11.0111b); sqrt=3, 3, 3, 4.
- xin=13 -> T=57 (11.1001b); sqrt=4 in modes 1/2/3, 3 in mode 0.
- xin=43 -> T=104 (110.1000b), remainder 192:
  - mode 1 -> sqrt=6.
  - mode 2 -> sqrt=7.
  - with PSDSQRT_REM_EN -> rem=192.
- xin=32'hFFFF_FFFF -> mode 1 gives sqrt=16'hFFFF, ovf=1; mode 0 gives sqrt=16'hFFFF, ovf=0.
- Control boundaries:
  - start xin=1057, then re-pulse start with xin=4 at cycle 5 -> second pulse ignored; sqrt=33 at done.
  - reset at cycle 10 of xin=4291 -> no done; outputs 0.
  - BPC=2 sweep of 1<<i for i=0..31 matches the model with latency 11.
